// File: rtl/pk_tx_sched.sv
// pk_tx_sched: shares one UART transmitter between two frame sources.
// Each source hands over a 1-4 byte frame. Frames are sent MSB byte first.
// Sources are arbitrated round-robin. Each byte waits a bounded time for the
// UART to acknowledge with tx_busy before the whole frame is aborted.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | no frame in flight, arbitrate when UART is free
//   SEND       | drive next byte and raise send
//   WAIT_BUSY  | send high, waiting for UART to acknowledge (timeout runs)
//   WAIT_TRANS | UART busy with current byte, wait for it to finish
module pk_tx_sched #(
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [1:0]  req,
  input  logic [2:0]  len0,
  input  logic [2:0]  len1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  tx_byte,
  output logic        send,
  input  logic        tx_busy
);

  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_TRANS} state_t;

  state_t        state, state_nxt;
  logic [31:0]   frame_q, frame_nxt;
  logic [2:0]    len_q, len_nxt;
  logic [1:0]    cnt_q, cnt_nxt;
  logic [TW-1:0] tcnt_q, tcnt_nxt;
  logic          owner_q, owner_nxt;
  logic          ptr_q, ptr_nxt;
  logic [1:0]    gnt_nxt, done_nxt;
  logic          err_nxt, send_nxt;
  logic [7:0]    tx_byte_nxt;

  logic          win;
  logic [2:0]    win_len;
  logic [31:0]   win_data;
  logic          accept;
  logic          last_byte;
  logic          tmo_hit;
  logic [7:0]    cur_byte;

  // Arbitration: the pointer only matters when both sources are requesting.
  always_comb begin
    win      = (&req) ? ptr_q : req[1];
    win_len  = win ? len1 : len0;
    win_data = win ? data1 : data0;
    accept   = (state == IDLE) && !tx_busy && (req != 2'b00);
    last_byte = ({1'b0, cnt_q} == (len_q - 3'd1));
    tmo_hit  = (tcnt_q == TCNT_LAST);
    case (cnt_q)
      2'd0:    cur_byte = frame_q[31:24];
      2'd1:    cur_byte = frame_q[23:16];
      2'd2:    cur_byte = frame_q[15:8];
      default: cur_byte = frame_q[7:0];
    endcase
  end

  // State register plus all registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state   <= IDLE;
      frame_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      send    <= 1'b0;
      tx_byte <= '0;
    end else begin
      state   <= state_nxt;
      frame_q <= frame_nxt;
      len_q   <= len_nxt;
      cnt_q   <= cnt_nxt;
      tcnt_q  <= tcnt_nxt;
      owner_q <= owner_nxt;
      ptr_q   <= ptr_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      send    <= send_nxt;
      tx_byte <= tx_byte_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept && (win_len != 3'd0)) state_nxt = SEND;
      SEND:       state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_nxt = WAIT_TRANS;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_TRANS: if (!tx_busy) state_nxt = last_byte ? IDLE : SEND;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low, held values default to hold.
  always_comb begin
    gnt_nxt     = 2'b00;
    done_nxt    = 2'b00;
    err_nxt     = 1'b0;
    send_nxt    = send;
    tx_byte_nxt = tx_byte;
    frame_nxt   = frame_q;
    len_nxt     = len_q;
    cnt_nxt     = cnt_q;
    tcnt_nxt    = tcnt_q;
    owner_nxt   = owner_q;
    ptr_nxt     = ptr_q;
    case (state)
      IDLE: begin
        send_nxt = 1'b0;
        if (accept) begin
          gnt_nxt = win ? 2'b10 : 2'b01;
          if (win_len == 3'd0) begin
            // Empty frame completes immediately and counts as served.
            done_nxt = win ? 2'b10 : 2'b01;
            ptr_nxt  = ~win;
          end else begin
            frame_nxt = win_data;
            len_nxt   = (win_len > 3'd4) ? 3'd4 : win_len;
            owner_nxt = win;
            cnt_nxt   = 2'd0;
          end
        end
      end
      SEND: begin
        tx_byte_nxt = cur_byte;
        send_nxt    = 1'b1;
        tcnt_nxt    = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          send_nxt = 1'b0;
        end else if (tmo_hit) begin
          send_nxt = 1'b0;
          done_nxt = owner_q ? 2'b10 : 2'b01;
          err_nxt  = 1'b1;
          ptr_nxt  = ~owner_q;
        end else begin
          tcnt_nxt = tcnt_q + TW'(1);
        end
      end
      WAIT_TRANS: begin
        send_nxt = 1'b0;
        if (!tx_busy) begin
          if (last_byte) begin
            done_nxt = owner_q ? 2'b10 : 2'b01;
            ptr_nxt  = ~owner_q;
          end else begin
            cnt_nxt = cnt_q + 2'd1;
          end
        end
      end
      default: send_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pk_tx_sched.sv
// Bench for pk_tx_sched: directed scenarios plus randomized frame mixes,
// compared against a frame-level round-robin model.
module tb_pk_tx_sched;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [2:0]  len0 = '0, len1 = '0;
  logic [31:0] data0 = '0, data1 = '0;
  logic [1:0]  gnt, done;
  logic        err, send, tx_busy;
  logic [7:0]  tx_byte;

  pk_tx_sched #(.BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_(rst_), .req(req), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .gnt(gnt), .done(done), .err(err),
    .tx_byte(tx_byte), .send(send), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  len;
    logic [31:0] data;
  } frame_t;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;

  frame_t     q0[$], q1[$];
  int         exp_gnt[$];
  logic [7:0] exp_bytes[$];

  int         obs_gnt[$], obs_gnt_cyc[$], obs_done[$], obs_done_cyc[$];
  int         rise_cyc[$], gaps[$];
  logic [7:0] obs_bytes[$];
  int         rises, send_hi, err_cnt, err_cyc, fall_cyc, start_cyc;
  bit         fall_valid, send_q, busy_q;

  bit uart_on = 1'b1;
  int busy_dly = 2, busy_hold = 10;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model: busy rises busy_dly cycles after send is seen, holds busy_hold cycles.
  initial begin : uart_model
    int phase, cnt;
    phase = 0; cnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #3;
      if (!rst_) begin
        tx_busy = 1'b0; phase = 0;
      end else begin
        case (phase)
          0: if (send && uart_on) begin cnt = busy_dly; phase = 1; end
          1: begin
            cnt--;
            if (cnt <= 0) begin tx_busy = 1'b1; cnt = busy_hold; phase = 2; end
          end
          default: begin
            cnt--;
            if (cnt <= 0) begin tx_busy = 1'b0; phase = 0; end
          end
        endcase
      end
    end
  end

  // Event monitor, samples outputs 1 time unit after each rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk); cyc++; #1;
      if (gnt != 2'b00) begin
        chk("gnt_onehot", $onehot(gnt), 1);
        obs_gnt.push_back(gnt[1] ? 1 : 0);
        obs_gnt_cyc.push_back(cyc);
        fall_valid = 1'b0;
      end
      if (done != 2'b00) begin
        chk("done_onehot", $onehot(done), 1);
        obs_done.push_back(done[1] ? 1 : 0);
        obs_done_cyc.push_back(cyc);
      end
      if (err) begin
        chk("err_with_done", (done != 2'b00), 1);
        err_cnt++; err_cyc = cyc;
      end
      if (send) send_hi++;
      if (send && !send_q) begin
        rises++;
        obs_bytes.push_back(tx_byte);
        rise_cyc.push_back(cyc);
        if (fall_valid) gaps.push_back(cyc - fall_cyc);
        fall_valid = 1'b0;
      end
      if (busy_q && !tx_busy) begin fall_cyc = cyc; fall_valid = 1'b1; end
      send_q = send;
      busy_q = tx_busy;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    obs_gnt.delete(); obs_gnt_cyc.delete(); obs_done.delete(); obs_done_cyc.delete();
    rise_cyc.delete(); gaps.delete(); obs_bytes.delete();
    rises = 0; send_hi = 0; err_cnt = 0; err_cyc = -1; fall_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_ = 1'b0; req = 2'b00;
    repeat (2) @(posedge clk);
    #2; rst_ = 1'b1;
    clear_obs();
  endtask

  task automatic present();
    if (q0.size() > 0) begin req[0] = 1'b1; len0 = q0[0].len; data0 = q0[0].data; end
    else begin req[0] = 1'b0; len0 = 3'($urandom); data0 = $urandom; end
    if (q1.size() > 0) begin req[1] = 1'b1; len1 = q1[0].len; data1 = q1[0].data; end
    else begin req[1] = 1'b0; len1 = 3'($urandom); data1 = $urandom; end
  endtask

  // Frame-level reference: round-robin over per-source frame queues.
  task automatic build_expect(input int ptr_init);
    frame_t c0[$], c1[$], f;
    int ptr, w, n;
    logic [31:0] tmp;
    c0 = q0; c1 = q1; ptr = ptr_init;
    exp_gnt.delete(); exp_bytes.delete();
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) w = ptr;
      else w = (c0.size() > 0) ? 0 : 1;
      f = (w == 0) ? c0.pop_front() : c1.pop_front();
      n = (f.len > 4) ? 4 : int'(f.len);
      for (int k = 0; k < n; k++) begin
        tmp = f.data << (8 * k);
        exp_bytes.push_back(tmp[31:24]);
      end
      exp_gnt.push_back(w);
      ptr = 1 - w;
    end
  endtask

  // Drives the queued frames; stops after all dones, or (stop_bytes>0) once the
  // given number of bytes went out and the UART is mid-byte.
  task automatic run_frames(input int budget, input int stop_bytes);
    int target, t;
    bit stop;
    target = q0.size() + q1.size();
    t = 0; stop = 1'b0;
    present();
    start_cyc = cyc;
    while (!stop && t < budget) begin
      @(posedge clk); #2; t++;
      if (gnt[0] && q0.size() > 0) void'(q0.pop_front());
      if (gnt[1] && q1.size() > 0) void'(q1.pop_front());
      present();
      if (stop_bytes > 0) stop = (obs_bytes.size() >= stop_bytes) && tx_busy && !send;
      else stop = (obs_done.size() >= target);
    end
    n_cmp++;
    assert (stop) else begin
      n_err++;
      $error("FAIL run_done: observed no completion after %0d cycles expected completion", t);
    end
  endtask

  task automatic check_stream(input string tag);
    int m;
    chk({tag, "_ngnt"}, obs_gnt.size(), exp_gnt.size());
    chk({tag, "_ndone"}, obs_done.size(), exp_gnt.size());
    chk({tag, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
    m = (obs_gnt.size() < exp_gnt.size()) ? obs_gnt.size() : exp_gnt.size();
    for (int i = 0; i < m; i++) chk({tag, "_gnt_src"}, obs_gnt[i], exp_gnt[i]);
    m = (obs_done.size() < exp_gnt.size()) ? obs_done.size() : exp_gnt.size();
    for (int i = 0; i < m; i++) chk({tag, "_done_src"}, obs_done[i], exp_gnt[i]);
    m = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
    for (int i = 0; i < m; i++) chk({tag, "_byte"}, obs_bytes[i], exp_bytes[i]);
  endtask

  initial begin : stimulus
    frame_t f;
    clear_obs();
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_send", send, 0);
    chk("rst_tx_byte", tx_byte, 0);

    // single 4-byte frame with latency and inter-byte gap checks
    busy_dly = 2; busy_hold = 10; uart_on = 1'b1;
    q0.push_back('{3'd4, 32'hDEADBEEF});
    build_expect(0);
    run_frames(2000, 0);
    check_stream("single");
    chk("single_sends", rises, 4);
    chk("single_err", err_cnt, 0);
    if (obs_bytes.size() == 4) begin
      chk("single_b0", obs_bytes[0], 8'hDE);
      chk("single_b3", obs_bytes[3], 8'hEF);
    end
    if (obs_gnt_cyc.size() > 0 && rise_cyc.size() > 0) begin
      chk("req_to_gnt", obs_gnt_cyc[0] - start_cyc, 1);
      chk("gnt_to_send", rise_cyc[0] - obs_gnt_cyc[0], 1);
    end
    chk("single_ngaps", gaps.size(), 3);
    // busy sampled low at edge X -> send visible after edge X+1
    foreach (gaps[i]) chk("busy_fall_to_send", gaps[i], 1);

    // simultaneous requests from reset
    do_reset();
    q0.push_back('{3'd1, 32'hA1000000});
    q1.push_back('{3'd1, 32'hB2000000});
    build_expect(0);
    run_frames(2000, 0);
    check_stream("simul");
    if (obs_gnt.size() == 2) chk("simul_first_src0", obs_gnt[0], 0);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{3'd1, $urandom});
      q1.push_back('{3'd1, $urandom});
    end
    build_expect(0);
    run_frames(3000, 0);
    check_stream("alt");
    if (obs_gnt_cyc.size() > 1 && obs_done_cyc.size() > 0)
      chk("back_to_back", obs_gnt_cyc[1] - obs_done_cyc[0], 1);

    // length boundaries
    do_reset();
    q1.push_back('{3'd0, 32'h11223344});
    build_expect(0);
    run_frames(200, 0);
    check_stream("len0");
    chk("len0_no_send", rises, 0);
    if (obs_gnt_cyc.size() > 0 && obs_done_cyc.size() > 0)
      chk("len0_same_cycle", obs_done_cyc[0], obs_gnt_cyc[0]);
    clear_obs();
    q1.push_back('{3'd7, 32'hCAFEF00D});
    build_expect(1);
    run_frames(2000, 0);
    check_stream("len7");
    chk("len7_sends", rises, 4);

    // busy never acknowledged
    do_reset();
    uart_on = 1'b0;
    q0.push_back('{3'd2, 32'h12345678});
    run_frames(500, 0);
    chk("tmo_err_cnt", err_cnt, 1);
    chk("tmo_sends", rises, 1);
    chk("tmo_send_width", send_hi, TMO);
    chk("tmo_send_low", send, 0);
    if (obs_done.size() > 0 && rise_cyc.size() > 0) begin
      chk("tmo_done_src", obs_done[0], 0);
      chk("tmo_latency", obs_done_cyc[0] - rise_cyc[0], TMO);
      chk("tmo_err_with_done", err_cyc, obs_done_cyc[0]);
    end
    if (obs_bytes.size() > 0) chk("tmo_byte", obs_bytes[0], 8'h12);
    clear_obs();
    uart_on = 1'b1;
    q0.push_back('{3'd1, 32'hA5000000});
    build_expect(1);
    run_frames(2000, 0);
    check_stream("after_tmo");
    chk("after_tmo_err", err_cnt, 0);

    // reset in WAIT_TRANS on byte 2 of a source-1 frame, after a source-0 frame
    do_reset();
    q0.push_back('{3'd1, 32'h5A000000});
    run_frames(2000, 0);
    clear_obs();
    q1.push_back('{3'd4, 32'h01020304});
    run_frames(2000, 2);
    rst_ = 1'b0; req = 2'b00;
    @(posedge clk); #2;
    rst_ = 1'b1;
    chk("midrst_send", send, 0);
    chk("midrst_tx_byte", tx_byte, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    q1.delete();
    clear_obs();
    repeat (5) @(posedge clk);
    #2;
    chk("midrst_no_done", obs_done.size(), 0);
    q0.push_back('{3'd2, 32'h77665544});
    q1.push_back('{3'd1, 32'h99000000});
    build_expect(0);
    run_frames(2000, 0);
    check_stream("post_rst");
    if (obs_gnt.size() > 0) chk("post_rst_src0_first", obs_gnt[0], 0);
    if (obs_bytes.size() > 0) chk("post_rst_byte0", obs_bytes[0], 8'h77);

    // randomized mixes; data/len are scrambled after each final grant
    for (int it = 0; it < 4; it++) begin
      do_reset();
      busy_dly = $urandom_range(1, 3);
      busy_hold = $urandom_range(1, 6);
      for (int i = 0, n = $urandom_range(1, 6); i < n; i++) begin
        f.len = 3'($urandom_range(0, 7)); f.data = $urandom;
        q0.push_back(f);
      end
      for (int i = 0, n = $urandom_range(1, 6); i < n; i++) begin
        f.len = 3'($urandom_range(0, 7)); f.data = $urandom;
        q1.push_back(f);
      end
      build_expect(0);
      run_frames(6000, 0);
      check_stream("rand");
      chk("rand_err", err_cnt, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
